// File: rtl/display_timing_gen.sv
// Raster timing generator: walks a (h,v) counter over the full line/frame
// totals and emits a two-stage registered pipeline. Stage 1 is the pixel
// fetch request; stage 2 lines up with a framebuffer read of 1-cycle
// latency and carries data enable, coordinates, syncs and frame markers.
module display_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       iCLOCK,
    input  logic       iRESET_SYNC,
    input  logic       iENA,
    output logic       oREQ,
    output logic [9:0] oREQ_X,
    output logic [9:0] oREQ_Y,
    output logic       oDE,
    output logic [9:0] oX,
    output logic [9:0] oY,
    output logic       oHSYNC,
    output logic       oVSYNC,
    output logic       oVBLANK,
    output logic       oFRAME_START,
    output logic [7:0] oFRAME_CNT
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Coordinates are 10 bits wide, so neither total may exceed 1024.
    if (H_TOTAL > 1024) begin : g_h_total_err
        $error("display_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_err
        $error("display_timing_gen: V_TOTAL exceeds 1024");
    end

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic       SYNC_ON    = SYNC_POL;
    localparam logic       SYNC_OFF   = ~SYNC_POL;

    logic [9:0] h;
    logic [9:0] v;
    logic       idle;
    logic       hs_hit;
    logic       vs_hit;
    logic       origin;

    // Reset and a low enable both park the whole generator.
    assign idle   = iRESET_SYNC || !iENA;
    assign hs_hit = (oREQ_X >= HS_FIRST) && (oREQ_X <= HS_LAST);
    assign vs_hit = (oREQ_Y >= VS_FIRST) && (oREQ_Y <= VS_LAST);
    assign origin = oREQ && (oREQ_X == 10'd0) && (oREQ_Y == 10'd0);

    // Raster position counter; line and frame wrap may coincide.
    always_ff @(posedge iCLOCK) begin
        if (idle) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (h == H_LAST) begin
            h <= 10'd0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    // Stage 1: fetch request and the position it refers to.
    always_ff @(posedge iCLOCK) begin
        if (idle) begin
            oREQ   <= 1'b0;
            oREQ_X <= 10'd0;
            oREQ_Y <= 10'd0;
        end else begin
            oREQ   <= (h < H_ACT) && (v < V_ACT);
            oREQ_X <= h;
            oREQ_Y <= v;
        end
    end

    // Stage 2: display-side timing, one cycle behind the request.
    always_ff @(posedge iCLOCK) begin
        if (idle) begin
            oDE          <= 1'b0;
            oX           <= 10'd0;
            oY           <= 10'd0;
            oHSYNC       <= SYNC_OFF;
            oVSYNC       <= SYNC_OFF;
            oVBLANK      <= 1'b0;
            oFRAME_START <= 1'b0;
        end else begin
            oDE          <= oREQ;
            oX           <= oREQ_X;
            oY           <= oREQ_Y;
            oHSYNC       <= hs_hit ? SYNC_ON : SYNC_OFF;
            oVSYNC       <= vs_hit ? SYNC_ON : SYNC_OFF;
            oVBLANK      <= (oREQ_Y >= V_ACT);
            oFRAME_START <= origin;
        end
    end

    // Frame counter: cleared only by reset, held while disabled.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            oFRAME_CNT <= 8'd0;
        end else if (iENA && origin) begin
            oFRAME_CNT <= oFRAME_CNT + 8'd1;
        end
    end

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen using a small raster so that hundreds of
// frames fit in a short run. A linear-index model predicts every output on
// every cycle; directed checks pin first-pixel latency, line/frame shapes,
// frame counter wrap, and enable/reset interruptions.
module tb_display_timing_gen;

  localparam int HA = 6;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 1;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;  // 12
  localparam int VT = VA + VF + VS + VB;  // 9
  localparam int FT = HT * VT;            // 108
  localparam bit POL = 1'b0;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       o_req;
  logic [9:0] o_req_x;
  logic [9:0] o_req_y;
  logic       o_de;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_vblank;
  logic       o_frame_start;
  logic [7:0] o_frame_cnt;

  int n_vec;
  int n_fail;

  display_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL)
  ) dut (
    .iCLOCK(clk),
    .iRESET_SYNC(rst),
    .iENA(ena),
    .oREQ(o_req),
    .oREQ_X(o_req_x),
    .oREQ_Y(o_req_y),
    .oDE(o_de),
    .oX(o_x),
    .oY(o_y),
    .oHSYNC(o_hsync),
    .oVSYNC(o_vsync),
    .oVBLANK(o_vblank),
    .oFRAME_START(o_frame_start),
    .oFRAME_CNT(o_frame_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // scoreboard: outputs derived from how many enabled edges have elapsed
  initial begin : scoreboard
    int run;
    int idx;
    int h1, v1, h2, v2;
    logic r, e;
    logic [7:0] m_fcnt;
    logic [63:0] act, exp;
    logic x_req, x_de, x_hs, x_vs, x_vb, x_fs;
    logic [9:0] x_rx, x_ry, x_x, x_y;
    run = 0;
    m_fcnt = 8'd0;
    forever begin
      @(posedge clk);
      r = rst;
      e = ena;
      if (r || !e) run = 0;
      else run++;
      if (r) m_fcnt = 8'd0;
      else if (e && run >= 2 && ((run - 2) % FT) == 0) m_fcnt = m_fcnt + 8'd1;
      #1;
      x_req = 1'b0; x_rx = 10'd0; x_ry = 10'd0;
      x_de = 1'b0; x_x = 10'd0; x_y = 10'd0;
      x_hs = ~POL; x_vs = ~POL; x_vb = 1'b0; x_fs = 1'b0;
      if (run >= 1) begin
        idx = run - 1;
        h1 = idx % HT;
        v1 = (idx / HT) % VT;
        x_req = (h1 < HA) && (v1 < VA);
        x_rx = 10'(h1);
        x_ry = 10'(v1);
      end
      if (run >= 2) begin
        idx = run - 2;
        h2 = idx % HT;
        v2 = (idx / HT) % VT;
        x_de = (h2 < HA) && (v2 < VA);
        x_x = 10'(h2);
        x_y = 10'(v2);
        x_hs = (h2 >= HA + HF && h2 < HA + HF + HS) ? POL : ~POL;
        x_vs = (v2 >= VA + VF && v2 < VA + VF + VS) ? POL : ~POL;
        x_vb = (v2 >= VA);
        x_fs = ((idx % FT) == 0);
      end
      act = 64'({o_req, o_req_x, o_req_y, o_de, o_x, o_y,
                 o_hsync, o_vsync, o_vblank, o_frame_start, o_frame_cnt});
      exp = 64'({x_req, x_rx, x_ry, x_de, x_x, x_y,
                 x_hs, x_vs, x_vb, x_fs, m_fcnt});
      check("cycle", act, exp);
    end
  end

  // directed sequence
  initial begin : main
    int guard;
    int hi, lo, lows, cnt, vs_lo, vb_hi;
    logic hs_by_x[HT];
    logic [7:0] fsave;
    logic [7:0] fexp;
    n_vec = 0;
    n_fail = 0;
    rst = 1'b1;
    ena = 1'b1;

    // reset held 3 cycles with enable high
    repeat (3) @(negedge clk);
    check("rst_req", 64'(o_req), 64'd0);
    check("rst_de", 64'(o_de), 64'd0);
    check("rst_hsync", 64'(o_hsync), 64'd1);
    check("rst_vsync", 64'(o_vsync), 64'd1);
    check("rst_fcnt", 64'(o_frame_cnt), 64'd0);

    // first pixel latency
    rst = 1'b0;
    @(negedge clk);
    check("e0_req", 64'(o_req), 64'd1);
    check("e0_req_x", 64'(o_req_x), 64'd0);
    check("e0_de", 64'(o_de), 64'd0);
    @(negedge clk);
    check("e1_de", 64'(o_de), 64'd1);
    check("e1_xy", 64'({o_x, o_y}), 64'd0);
    check("e1_fs", 64'(o_frame_start), 64'd1);
    check("e1_fcnt", 64'(o_frame_cnt), 64'd1);

    // data enable shape of line 0
    hi = 0;
    while (o_de && hi < 50) begin hi++; @(negedge clk); end
    lo = 0;
    while (!o_de && lo < 50) begin lo++; @(negedge clk); end
    check("de_high_len", 64'(hi), 64'(HA));
    check("de_low_len", 64'(lo), 64'(HT - HA));

    // hsync shape of line 1
    guard = 0;
    while (!(o_x == 10'd0 && o_y == 10'd1) && guard < 200) begin guard++; @(negedge clk); end
    check("wait_line1", 64'(guard < 200), 64'd1);
    lows = 0;
    for (int i = 0; i < HT; i++) begin
      hs_by_x[i] = o_hsync;
      if (!o_hsync) lows++;
      @(negedge clk);
    end
    check("hs_low_len", 64'(lows), 64'(HS));
    check("hs_x7", 64'(hs_by_x[7]), 64'd1);
    check("hs_x8", 64'(hs_by_x[8]), 64'd0);
    check("hs_x10", 64'(hs_by_x[10]), 64'd0);
    check("hs_x11", 64'(hs_by_x[11]), 64'd1);
    check("line_period", 64'(o_x == 10'd0 && o_y == 10'd2), 64'd1);

    // frame period, vsync and vblank totals
    guard = 0;
    while (!o_frame_start && guard < 300) begin guard++; @(negedge clk); end
    check("wait_fs", 64'(guard < 300), 64'd1);
    cnt = 0; vs_lo = 0; vb_hi = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (!o_vsync) vs_lo++;
      if (o_vblank) vb_hi++;
    end while (!o_frame_start && cnt < 500);
    check("frame_period", 64'(cnt), 64'(FT));
    check("vs_low_cycles", 64'(vs_lo), 64'(VS * HT));
    check("vblank_cycles", 64'(vb_hi), 64'((VT - VA) * HT));

    // frame counter wrap 255 -> 0
    guard = 0;
    while (!(o_frame_start && o_frame_cnt == 8'd255) && guard < 30000) begin guard++; @(negedge clk); end
    check("wait_fcnt255", 64'(guard < 30000), 64'd1);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!o_frame_start && cnt < 500);
    check("wrap_period", 64'(cnt), 64'(FT));
    check("fcnt_wrap", 64'(o_frame_cnt), 64'd0);

    // enable dropped with counter at (9,5): inside hsync and vsync
    guard = 0;
    while (!(o_req_x == 10'd8 && o_req_y == 10'd5) && guard < 300) begin guard++; @(negedge clk); end
    check("wait_9_5", 64'(guard < 300), 64'd1);
    fsave = o_frame_cnt;
    ena = 1'b0;
    @(negedge clk);
    check("dis_de", 64'(o_de), 64'd0);
    check("dis_req", 64'(o_req), 64'd0);
    check("dis_syncs", 64'({o_hsync, o_vsync}), 64'd3);
    check("dis_xy", 64'({o_x, o_y}), 64'd0);
    check("dis_fcnt", 64'(o_frame_cnt), 64'(fsave));
    repeat (3) @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    check("re_e0_req", 64'(o_req), 64'd1);
    check("re_e0_de", 64'(o_de), 64'd0);
    @(negedge clk);
    fexp = fsave + 8'd1;
    check("re_e1_de", 64'(o_de), 64'd1);
    check("re_e1_fs", 64'(o_frame_start), 64'd1);
    check("re_e1_fcnt", 64'(o_frame_cnt), 64'(fexp));

    // reset asserted mid-frame
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_fcnt", 64'(o_frame_cnt), 64'd0);
    check("mid_rst_de", 64'(o_de), 64'd0);
    check("mid_rst_syncs", 64'({o_hsync, o_vsync}), 64'd3);
    check("mid_rst_xy", 64'({o_req_x, o_req_y, o_x, o_y}), 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
